// File: rtl/mem_access_stage_pkg.sv
// Shared types and defaults for the MEM pipeline stage.
package mem_access_stage_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int FWD_W_DEF    = 4;
  localparam int MAX_WAIT_DEF = 15;
  localparam int WAIT_CNT_W   = $clog2(MAX_WAIT_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  function automatic logic is_word_aligned(input logic [1:0] byte_lsb);
    return byte_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request bus between the MEM stage (master) and memory (slave).
// mem_req rises with stable mem_we/mem_addr/mem_wdata and holds until the single-cycle
// mem_ack pulse; mem_rdata is valid only in the ack cycle, and mem_req drops the cycle after.
interface mem_access_stage_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage_wait_timer.sv
// Wait-cycle counter for an outstanding memory access; flags expiry at MAX_WAIT.
module mem_access_stage_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues word loads/stores over req/ack and stalls the front
// of the pipeline while an access is outstanding.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FWD_W    = FWD_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] ALU_Res_i,
  input  logic [DATA_W-1:0] Store_Data_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [FWD_W-1:0]  Forward_Data_i,
  input  logic              WB_i,
  mem_access_stage_if.master mem,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] ALU_Res_o,
  output logic [DATA_W-1:0] Read_Data_o,
  output logic [FWD_W-1:0]  Forward_Data_o,
  output logic              WB_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output mem_state_t        state_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  mem_state_t        state_q;
  logic [DATA_W-3:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              err_q;

  logic op, aligned, launch, in_idle, in_wait, in_resp, expire;

  // rst_i gates the op decode so a held EX/MEM op cannot stall while in reset.
  assign op      = rst_i & (MemRead_i | MemWrite_i);
  assign aligned = is_word_aligned(ALU_Res_i[1:0]);
  assign in_idle = (state_q == IDLE);
  assign in_wait = (state_q == WAIT);
  assign in_resp = (state_q == RESP);
  assign launch  = in_idle & op & aligned;

  assign misalign_o  = in_idle & op & ~aligned;
  assign stall_o     = launch | in_wait;
  assign bus_err_o   = in_resp & err_q;
  assign WB_o        = WB_i & ~stall_o & ~misalign_o & ~(in_resp & err_q);
  assign Read_Data_o = in_resp ? rdata_q : '0;

  assign pc_o           = pc_i;
  assign ALU_Res_o      = ALU_Res_i;
  assign Forward_Data_o = Forward_Data_i;
  assign state_o        = state_q;

  assign mem.mem_req   = in_wait;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q, 2'b00};
  assign mem.mem_wdata = wdata_q;

  mem_access_stage_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (~in_wait),
    .en_i     (in_wait),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q <= WAIT;
            addr_q  <= ALU_Res_i[DATA_W-1:2];
            wdata_q <= Store_Data_i;
            we_q    <= MemWrite_i;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        WAIT: begin
          // An ack in the expiry cycle still completes the access normally.
          if (mem.mem_ack) begin
            rdata_q <= we_q ? '0 : mem.mem_rdata;
            state_q <= RESP;
          end else if (expire) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores, misalign,
// timeout, ack-at-expiry and reset mid-access.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int DW = 32;
  localparam int FW = 4;
  localparam int MW = 15;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [DW-1:0] pc_i, ALU_Res_i, Store_Data_i;
  logic          MemRead_i, MemWrite_i, WB_i;
  logic [FW-1:0] Forward_Data_i;
  logic [DW-1:0] pc_o, ALU_Res_o, Read_Data_o;
  logic [FW-1:0] Forward_Data_o;
  logic          WB_o, stall_o, misalign_o, bus_err_o;
  mem_state_t    state_o;

  mem_access_stage_if #(.DATA_W(DW)) mem_bus ();

  mem_access_stage #(.DATA_W(DW), .FWD_W(FW), .MAX_WAIT(MW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pc_i           (pc_i),
    .ALU_Res_i      (ALU_Res_i),
    .Store_Data_i   (Store_Data_i),
    .MemRead_i      (MemRead_i),
    .MemWrite_i     (MemWrite_i),
    .Forward_Data_i (Forward_Data_i),
    .WB_i           (WB_i),
    .mem            (mem_bus.master),
    .pc_o           (pc_o),
    .ALU_Res_o      (ALU_Res_o),
    .Read_Data_o    (Read_Data_o),
    .Forward_Data_o (Forward_Data_o),
    .WB_o           (WB_o),
    .stall_o        (stall_o),
    .misalign_o     (misalign_o),
    .bus_err_o      (bus_err_o),
    .state_o        (state_o)
  );

  // ---------------- scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  int            stalls;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    pc_i = '0; ALU_Res_i = '0; Store_Data_i = '0;
    MemRead_i = 1'b0; MemWrite_i = 1'b0; WB_i = 1'b0; Forward_Data_i = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'hBAD0_BAD0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  // Drives one memory op; ack_cycle is the 1-based WAIT cycle of the ack (0 = never).
  // Returns at the negedge of the first non-stalled cycle with the stall count in stalls.
  task automatic run_access(input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic rd, input logic wr, input logic wb,
                            input int ack_cycle, input logic [DW-1:0] rdata);
    ALU_Res_i = addr; Store_Data_i = wdata; MemRead_i = rd; MemWrite_i = wr; WB_i = wb;
    pc_i = addr + 32'h1000; Forward_Data_i = 4'h7;
    stalls = 0;
    for (int c = 0; c < MW + 8; c++) begin
      mem_bus.mem_ack   = (ack_cycle != 0) && (c == ack_cycle);
      mem_bus.mem_rdata = mem_bus.mem_ack ? rdata : 32'hBAD0_BAD0;
      @(negedge clk_i);
      if (c == 0) check_bit("req_idle", mem_bus.mem_req, 1'b0);
      if (c == 1) begin
        check_bit("req_wait", mem_bus.mem_req, 1'b1);
        check_bit("we", mem_bus.mem_we, wr);
        check("addr", mem_bus.mem_addr, addr & 32'hFFFF_FFFC);
        if (wr) check("wdata", mem_bus.mem_wdata, wdata);
        check_bit("wb_bubble", WB_o, 1'b0);
      end
      if (!stall_o) break;
      stalls++;
      next_cycle();
    end
    mem_bus.mem_ack = 1'b0;
  endtask

  // Checks the RESP cycle against the head of the expected queue.
  task automatic check_resp(input string tag, input int exp_stalls, input logic exp_wb,
                            input logic exp_err);
    exp_rd = exp_q.pop_front();
    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_state"}, 32'(state_o), 32'(RESP));
    check({tag, "_rdata"}, Read_Data_o, exp_rd);
    check_bit({tag, "_wb"}, WB_o, exp_wb);
    check_bit({tag, "_buserr"}, bus_err_o, exp_err);
    check_bit({tag, "_req"}, mem_bus.mem_req, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    clear_inputs();
    #3;
    check_bit("rst_req", mem_bus.mem_req, 1'b0);
    check_bit("rst_stall", stall_o, 1'b0);
    check_bit("rst_misalign", misalign_o, 1'b0);
    check_bit("rst_buserr", bus_err_o, 1'b0);
    check("rst_rdata", Read_Data_o, 32'h0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    next_cycle();
    rst_i = 1'b1;

    // ALU instruction passes straight through
    pc_i = 32'h40; ALU_Res_i = 32'h55; Forward_Data_i = 4'h5; WB_i = 1'b1;
    @(negedge clk_i);
    check_bit("alu_wb", WB_o, 1'b1);
    check_bit("alu_stall", stall_o, 1'b0);
    check("alu_rdata", Read_Data_o, 32'h0);
    check("alu_pc", pc_o, 32'h40);
    check("alu_res", ALU_Res_o, 32'h55);
    check("alu_fwd", 32'(Forward_Data_o), 32'h5);
    next_cycle();

    // Load 0x100, ack in 3rd WAIT cycle: 4 stall cycles
    exp_q.push_back(32'hDEAD_BEEF);
    run_access(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'hDEAD_BEEF);
    check_resp("load", 4, 1'b1, 1'b0);
    next_cycle();

    // Store 0x104 issued back-to-back, immediate ack: 2 stall cycles
    exp_q.push_back(32'h0);
    run_access(32'h104, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1, 32'h5555_5555);
    check_resp("store", 2, 1'b0, 1'b0);
    next_cycle();
    clear_inputs();

    // Misaligned load: flagged, no request, no stall, no write-back
    ALU_Res_i = 32'h102; MemRead_i = 1'b1; WB_i = 1'b1;
    @(negedge clk_i);
    check_bit("mis_flag", misalign_o, 1'b1);
    check_bit("mis_req", mem_bus.mem_req, 1'b0);
    check_bit("mis_stall", stall_o, 1'b0);
    check_bit("mis_wb", WB_o, 1'b0);
    next_cycle();
    clear_inputs();
    @(negedge clk_i);
    check_bit("mis_pulse", misalign_o, 1'b0);
    check("mis_state", 32'(state_o), 32'(IDLE));
    next_cycle();

    // Load never acked: IDLE + 16 WAIT cycles, then bus error in RESP
    exp_q.push_back(32'h0);
    run_access(32'h200, 32'h0, 1'b1, 1'b0, 1'b1, 0, 32'h0);
    check_resp("timeout", 17, 1'b0, 1'b1);
    next_cycle();
    clear_inputs();
    @(negedge clk_i);
    check_bit("timeout_pulse", bus_err_o, 1'b0);
    check("timeout_idle", 32'(state_o), 32'(IDLE));
    next_cycle();

    // Ack on WAIT cycle 15: completes normally
    exp_q.push_back(32'hA5A5_0F0F);
    run_access(32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 15, 32'hA5A5_0F0F);
    check_resp("ack15", 16, 1'b1, 1'b0);
    next_cycle();

    // Ack in the expiry cycle itself: ack wins
    exp_q.push_back(32'hCAFE_F00D);
    run_access(32'h304, 32'h0, 1'b1, 1'b0, 1'b1, 16, 32'hCAFE_F00D);
    check_resp("ack16", 17, 1'b1, 1'b0);
    next_cycle();

    // Read and write both set: behaves as a store, read data stays 0
    exp_q.push_back(32'h0);
    run_access(32'h408, 32'h0BAD_CAFE, 1'b1, 1'b1, 1'b0, 2, 32'h1111_1111);
    check_resp("rdwr", 3, 1'b0, 1'b0);
    next_cycle();
    clear_inputs();

    // Reset in the middle of WAIT, then a late ack in IDLE
    ALU_Res_i = 32'h500; MemRead_i = 1'b1; WB_i = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    check("pre_rst_state", 32'(state_o), 32'(WAIT));
    #1;
    rst_i = 1'b0;
    #1;
    check_bit("mid_rst_req", mem_bus.mem_req, 1'b0);
    check_bit("mid_rst_stall", stall_o, 1'b0);
    check("mid_rst_state", 32'(state_o), 32'(IDLE));
    next_cycle();
    rst_i = 1'b1;
    clear_inputs();
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h9999_9999;
    @(negedge clk_i);
    check_bit("late_ack_stall", stall_o, 1'b0);
    check_bit("late_ack_req", mem_bus.mem_req, 1'b0);
    next_cycle();
    mem_bus.mem_ack = 1'b0;
    @(negedge clk_i);
    check("late_ack_state", 32'(state_o), 32'(IDLE));
    check("late_ack_rdata", Read_Data_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
